// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving bus handshakes, strobes and mux selects.
// Define RISCV_MC_PERF_CNT_EN to build the cycle_cnt/instret_cnt performance counters.
module riscv_mc_ctrl #(
    parameter int unsigned IBUS_DATA_WIDTH = 32,
    parameter int unsigned DBUS_DATA_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ibus_valid,
    input  logic                       ibus_ready,
    input  logic [IBUS_DATA_WIDTH-1:0] ibus_rdata,
    output logic                       dbus_valid,
    output logic                       dbus_we,
    input  logic                       dbus_ready,
    input  logic                       branch_taken,
    output logic                       ir_we,
    output logic                       pc_we,
    output logic [1:0]                 pc_sel,
    output logic                       rf_we,
    output logic [1:0]                 wb_sel,
    output logic                       alu_a_sel,
    output logic                       alu_b_sel,
    output logic                       illegal_instr,
    output logic [DBUS_DATA_WIDTH-1:0] cycle_cnt,
    output logic [DBUS_DATA_WIDTH-1:0] instret_cnt
);

    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StTrap
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] opcode_q, opcode_d;
    logic [1:0] pc_sel_q, pc_sel_d;
    logic [1:0] wb_sel_q, wb_sel_d;
    logic       alu_a_sel_q, alu_a_sel_d;
    logic       alu_b_sel_q, alu_b_sel_d;

    // Only the opcode field of the fetched word is consumed here.
    logic unused_rdata;
    assign unused_rdata = ^ibus_rdata[IBUS_DATA_WIDTH-1:7];

    logic is_op, is_op32, is_op_imm, is_op_imm32, is_load, is_store;
    logic is_branch, is_lui, is_auipc, is_jal, is_jalr, is_legal;

    assign is_op       = (opcode_q == OpcOp);
    assign is_op32     = (opcode_q == OpcOp32);
    assign is_op_imm   = (opcode_q == OpcOpImm);
    assign is_op_imm32 = (opcode_q == OpcOpImm32);
    assign is_load     = (opcode_q == OpcLoad);
    assign is_store    = (opcode_q == OpcStore);
    assign is_branch   = (opcode_q == OpcBranch);
    assign is_lui      = (opcode_q == OpcLui);
    assign is_auipc    = (opcode_q == OpcAuipc);
    assign is_jal      = (opcode_q == OpcJal);
    assign is_jalr     = (opcode_q == OpcJalr);
    assign is_legal    = is_op | is_op32 | is_op_imm | is_op_imm32 | is_load | is_store |
                         is_branch | is_lui | is_auipc | is_jal | is_jalr;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        pc_sel_d    = pc_sel_q;
        wb_sel_d    = wb_sel_q;
        alu_a_sel_d = alu_a_sel_q;
        alu_b_sel_d = alu_b_sel_q;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (ibus_ready) begin
                    opcode_d = ibus_rdata[6:0];
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                state_d     = is_legal ? StExec : StTrap;
                alu_a_sel_d = is_auipc;
                alu_b_sel_d = is_op_imm | is_op_imm32 | is_load | is_store | is_auipc | is_jalr;
                if (is_load)                wb_sel_d = 2'b01;
                else if (is_jal || is_jalr) wb_sel_d = 2'b10;
                else if (is_lui)            wb_sel_d = 2'b11;
                else                        wb_sel_d = 2'b00;
                if (is_jal)                 pc_sel_d = 2'b01;
                else if (is_jalr)           pc_sel_d = 2'b10;
                else if (is_branch)         pc_sel_d = {1'b0, branch_taken};
                else                        pc_sel_d = 2'b00;
            end
            StExec: begin
                if (is_branch) begin
                    pc_sel_d = {1'b0, branch_taken};
                    state_d  = StFetch;
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dbus_ready) state_d = is_store ? StFetch : StWb;
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            opcode_q    <= '0;
            pc_sel_q    <= '0;
            wb_sel_q    <= '0;
            alu_a_sel_q <= 1'b0;
            alu_b_sel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            pc_sel_q    <= pc_sel_d;
            wb_sel_q    <= wb_sel_d;
            alu_a_sel_q <= alu_a_sel_d;
            alu_b_sel_q <= alu_b_sel_d;
        end
    end

    // Only ir_we, MEM-state pc_we and EXEC-state pc_sel see inputs combinationally.
    assign ibus_valid    = (state_q == StFetch);
    assign ir_we         = (state_q == StFetch) & ibus_ready;
    assign dbus_valid    = (state_q == StMem);
    assign dbus_we       = (state_q == StMem) & is_store;
    assign rf_we         = (state_q == StWb);
    assign pc_we         = ((state_q == StExec) & is_branch) |
                           ((state_q == StMem) & is_store & dbus_ready) |
                           (state_q == StWb);
    assign pc_sel        = ((state_q == StExec) && is_branch) ? {1'b0, branch_taken} : pc_sel_q;
    assign wb_sel        = wb_sel_q;
    assign alu_a_sel     = alu_a_sel_q;
    assign alu_b_sel     = alu_b_sel_q;
    assign illegal_instr = (state_q == StTrap);

`ifdef RISCV_MC_PERF_CNT_EN
    logic [DBUS_DATA_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [DBUS_DATA_WIDTH-1:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + DBUS_DATA_WIDTH'(1);
        instret_cnt_d = pc_we ? instret_cnt_q + DBUS_DATA_WIDTH'(1) : instret_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
